mips_mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS core: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over several clocks per instruction. It replaces the static per-run control inputs the single-cycle datapath takes today (RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch) with per-state control words. It also adds memory wait-state handshaking, a wait timeout, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register's opcode field and the multicycle datapath.

---
 rtl/mips_mc_ctrl.sv | 151 +++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM with memory wait handshake,
// wait timeout fault, illegal-opcode trap and retired-instruction counter.
module mips_mc_ctrl #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH = 32,
  parameter int WAIT_MAX = 15,
  parameter logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00,
  parameter logic [OPCODE_WIDTH-1:0] OP_LW = 6'h23,
  parameter logic [OPCODE_WIDTH-1:0] OP_SW = 6'h2B,
  parameter logic [OPCODE_WIDTH-1:0] OP_BEQ = 6'h04,
  parameter logic [OPCODE_WIDTH-1:0] OP_J = 6'h02,
  parameter logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'h08
) (
  input  logic                    c_clk,
  input  logic                    c_rst,
  input  logic                    c_i_ce,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic                    c_i_mem_ready,
  output logic                    c_o_PCWrite,
  output logic                    c_o_PCWriteCond,
  output logic                    c_o_IorD,
  output logic                    c_o_MemRead,
  output logic                    c_o_MemWrite,
  output logic                    c_o_MemtoReg,
  output logic                    c_o_IRWrite,
  output logic                    c_o_RegWrite,
  output logic                    c_o_RegDst,
  output logic                    c_o_ALUSrcA,
  output logic [1:0]              c_o_ALUSrcB,
  output logic [1:0]              c_o_ALUOp,
  output logic [1:0]              c_o_PCSource,
  output logic                    c_o_illegal,
  output logic                    c_o_fault,
  output logic [CNT_WIDTH-1:0]    c_o_retired
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    EXEC, R_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB, FAULT
  } state_t;
  state_t state_q, state_d, done_st;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic mem_st, timeout, retire, legal;
  assign mem_st = state_q inside {FETCH, MEM_RD, MEM_WR};
  // the WAIT_MAX-th consecutive not-ready cycle faults; ready in that cycle wins
  assign timeout = mem_st && !c_i_mem_ready && wait_q == WW'(WAIT_MAX - 1);
  assign legal = c_i_opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  assign done_st = c_i_ce ? FETCH : IDLE;
  assign retire = state_q inside {MEM_WB, R_WB, BRANCH, JUMP, IMM_WB} ||
                  (state_q == MEM_WR && c_i_mem_ready);
  assign c_o_retired = retired_q;
  always_ff @(posedge c_clk) begin
    if (!c_rst) begin
      state_q <= IDLE;
      wait_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wait_d = (mem_st && !c_i_mem_ready && !timeout) ? wait_q + 1'b1 : '0;
    retired_d = retire ? retired_q + CNT_WIDTH'(1) : retired_q;
    case (state_q)
      IDLE: state_d = c_i_ce ? FETCH : IDLE;
      FETCH: state_d = timeout ? FAULT : c_i_mem_ready ? DECODE : FETCH;
      DECODE: state_d = (c_i_opcode == OP_LW || c_i_opcode == OP_SW) ? MEM_ADDR :
                        c_i_opcode == OP_RTYPE ? EXEC :
                        c_i_opcode == OP_BEQ ? BRANCH :
                        c_i_opcode == OP_J ? JUMP :
                        c_i_opcode == OP_ADDI ? IMM_EXEC : FETCH;
      MEM_ADDR: state_d = (c_i_opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: state_d = timeout ? FAULT : c_i_mem_ready ? MEM_WB : MEM_RD;
      MEM_WR: state_d = timeout ? FAULT : c_i_mem_ready ? done_st : MEM_WR;
      EXEC: state_d = R_WB;
      IMM_EXEC: state_d = IMM_WB;
      MEM_WB, R_WB, BRANCH, JUMP, IMM_WB: state_d = done_st;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    c_o_PCWrite = 1'b0;
    c_o_PCWriteCond = 1'b0;
    c_o_IorD = 1'b0;
    c_o_MemRead = 1'b0;
    c_o_MemWrite = 1'b0;
    c_o_MemtoReg = 1'b0;
    c_o_IRWrite = 1'b0;
    c_o_RegWrite = 1'b0;
    c_o_RegDst = 1'b0;
    c_o_ALUSrcA = 1'b0;
    c_o_ALUSrcB = 2'b00;
    c_o_ALUOp = 2'b00;
    c_o_PCSource = 2'b00;
    c_o_illegal = 1'b0;
    c_o_fault = state_q == FAULT;
    case (state_q)
      FETCH: begin
        c_o_MemRead = 1'b1;
        c_o_ALUSrcB = 2'b01;
        c_o_IRWrite = c_i_mem_ready;
        c_o_PCWrite = c_i_mem_ready;
      end
      DECODE: begin
        c_o_ALUSrcB = 2'b11;
        c_o_illegal = !legal;
      end
      MEM_ADDR, IMM_EXEC: begin
        c_o_ALUSrcA = 1'b1;
        c_o_ALUSrcB = 2'b10;
      end
      MEM_RD: begin
        c_o_MemRead = 1'b1;
        c_o_IorD = 1'b1;
      end
      MEM_WB: begin
        c_o_RegWrite = 1'b1;
        c_o_MemtoReg = 1'b1;
      end
      MEM_WR: begin
        c_o_MemWrite = 1'b1;
        c_o_IorD = 1'b1;
      end
      EXEC: begin
        c_o_ALUSrcA = 1'b1;
        c_o_ALUOp = 2'b10;
      end
      R_WB: begin
        c_o_RegWrite = 1'b1;
        c_o_RegDst = 1'b1;
      end
      BRANCH: begin
        c_o_ALUSrcA = 1'b1;
        c_o_ALUOp = 2'b01;
        c_o_PCWriteCond = 1'b1;
        c_o_PCSource = 2'b01;
      end
      JUMP: begin
        c_o_PCWrite = 1'b1;
        c_o_PCSource = 2'b10;
      end
      IMM_WB: c_o_RegWrite = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scenario tasks plus randomized instruction stream, checked
// against per-instruction phase sequences built from the opcode rules.
module tb_mips_mc_ctrl;
  localparam int WM = 15;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;
  localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMB = 4, PMW = 5, PEX = 6,
                 PRW = 7, PBR = 8, PJ = 9, PIE = 10, PIW = 11, PFT = 12;
  // control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //   RegWrite,RegDst,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],illegal,fault}
  localparam logic [17:0] PCW = 18'h20000, PCC = 18'h10000, IORD = 18'h08000,
    MR = 18'h04000, MW = 18'h02000, M2R = 18'h01000, IRW = 18'h00800,
    RW = 18'h00400, RD = 18'h00200, SA = 18'h00100, SB4 = 18'h00040,
    SBI = 18'h00080, SBS = 18'h000C0, ASUB = 18'h00010, AFN = 18'h00020,
    PSO = 18'h00004, PSJ = 18'h00008, ILL = 18'h00002, FLT = 18'h00001;

  logic c_clk = 1'b0, c_rst, c_i_ce, c_i_mem_ready;
  logic [5:0] c_i_opcode;
  logic [17:0] wa, wb;
  logic [31:0] ra;
  logic [3:0] rb;
  int total = 0, bad = 0;
  int unsigned cnt = 0;
  int ph_q[$];
  bit rd_q[$];
  bit flt;

  always #5 c_clk = ~c_clk;

  mips_mc_ctrl dut (
    .c_clk(c_clk), .c_rst(c_rst), .c_i_ce(c_i_ce), .c_i_opcode(c_i_opcode),
    .c_i_mem_ready(c_i_mem_ready), .c_o_PCWrite(wa[17]), .c_o_PCWriteCond(wa[16]),
    .c_o_IorD(wa[15]), .c_o_MemRead(wa[14]), .c_o_MemWrite(wa[13]),
    .c_o_MemtoReg(wa[12]), .c_o_IRWrite(wa[11]), .c_o_RegWrite(wa[10]),
    .c_o_RegDst(wa[9]), .c_o_ALUSrcA(wa[8]), .c_o_ALUSrcB(wa[7:6]),
    .c_o_ALUOp(wa[5:4]), .c_o_PCSource(wa[3:2]), .c_o_illegal(wa[1]),
    .c_o_fault(wa[0]), .c_o_retired(ra)
  );

  mips_mc_ctrl #(.CNT_WIDTH(4)) dut4 (
    .c_clk(c_clk), .c_rst(c_rst), .c_i_ce(c_i_ce), .c_i_opcode(c_i_opcode),
    .c_i_mem_ready(c_i_mem_ready), .c_o_PCWrite(wb[17]), .c_o_PCWriteCond(wb[16]),
    .c_o_IorD(wb[15]), .c_o_MemRead(wb[14]), .c_o_MemWrite(wb[13]),
    .c_o_MemtoReg(wb[12]), .c_o_IRWrite(wb[11]), .c_o_RegWrite(wb[10]),
    .c_o_RegDst(wb[9]), .c_o_ALUSrcA(wb[8]), .c_o_ALUSrcB(wb[7:6]),
    .c_o_ALUOp(wb[5:4]), .c_o_PCSource(wb[3:2]), .c_o_illegal(wb[1]),
    .c_o_fault(wb[0]), .c_o_retired(rb)
  );

  function automatic logic [17:0] exp_word(int p, logic r, logic ill);
    case (p)
      PF: return MR | SB4 | (r ? (PCW | IRW) : 18'h0);
      PD: return SBS | (ill ? ILL : 18'h0);
      PMA, PIE: return SA | SBI;
      PMR: return IORD | MR;
      PMB: return RW | M2R;
      PMW: return MW | IORD;
      PEX: return SA | AFN;
      PRW: return RW | RD;
      PBR: return SA | ASUB | PCC | PSO;
      PJ: return PCW | PSJ;
      PIW: return RW;
      PFT: return FLT;
      default: return 18'h0;
    endcase
  endfunction

  task automatic push1(input int p);
    ph_q.push_back(p);
    rd_q.push_back(1'b0);
  endtask

  // n not-ready cycles then the ready cycle; WM or more ends in the fault state
  task automatic push_wait(input int p, input int n);
    for (int i = 0; i < (n < WM ? n : WM); i++) push1(p);
    if (n >= WM) begin
      flt = 1'b1;
      repeat (3) push1(PFT);
    end else begin
      ph_q.push_back(p);
      rd_q.push_back(1'b1);
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    c_rst = 1'b0;
    c_i_ce = 1'b1;
    c_i_mem_ready = 1'($urandom);
    c_i_opcode = 6'($urandom);
    repeat (n) begin
      @(posedge c_clk);
      #1;
    end
    cnt = 0;
    @(negedge c_clk);
    total++;
    if (wa !== 18'h0) begin bad++; $display("FAIL %s reset ctrl got=%h exp=%h", tag, wa, 18'h0); end
    total++;
    if (ra !== 32'd0 || rb !== 4'd0) begin bad++; $display("FAIL %s reset retired got=%0d/%0d exp=0", tag, ra, rb); end
    c_rst = 1'b1;
    @(posedge c_clk);
    #1;
  endtask

  task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                          input bit stop, input int cut, input string tag);
    bit legal, last;
    int n, p, k;
    logic [17:0] e;
    legal = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    ph_q.delete();
    rd_q.delete();
    flt = 1'b0;
    push_wait(PF, fw);
    if (!flt) begin
      push1(PD);
      if (op == OP_LW || op == OP_SW) begin
        push1(PMA);
        push_wait(op == OP_LW ? PMR : PMW, mw);
        if (!flt && op == OP_LW) push1(PMB);
      end
      else if (op == OP_R) begin push1(PEX); push1(PRW); end
      else if (op == OP_BEQ) push1(PBR);
      else if (op == OP_J) push1(PJ);
      else if (op == OP_ADDI) begin push1(PIE); push1(PIW); end
    end
    n = (cut >= 0 && cut < ph_q.size()) ? cut : ph_q.size();
    for (int i = 0; i < n; i++) begin
      p = ph_q[i];
      last = legal && !flt && i == ph_q.size() - 1;
      c_i_mem_ready = (p == PF || p == PMR || p == PMW) ? rd_q[i] : 1'($urandom);
      c_i_opcode = (p == PF) ? 6'($urandom) : op;
      c_i_ce = last ? !stop : 1'($urandom);
      e = exp_word(p, c_i_mem_ready, !legal);
      @(negedge c_clk);
      total++;
      if (wa !== e) begin bad++; $display("FAIL %s ctrl cyc=%0d ph=%0d got=%h exp=%h", tag, i, p, wa, e); end
      total++;
      if (wb !== e) begin bad++; $display("FAIL %s ctrl4 cyc=%0d ph=%0d got=%h exp=%h", tag, i, p, wb, e); end
      total++;
      if (ra !== 32'(cnt)) begin bad++; $display("FAIL %s retired cyc=%0d got=%0d exp=%0d", tag, i, ra, 32'(cnt)); end
      total++;
      if (rb !== 4'(cnt)) begin bad++; $display("FAIL %s retired4 cyc=%0d got=%0d exp=%0d", tag, i, rb, 4'(cnt)); end
      @(posedge c_clk);
      #1;
      if (last) cnt++;
    end
    if (stop && legal && n == ph_q.size()) begin
      k = $urandom_range(1, 3);
      for (int i = 0; i <= k; i++) begin
        c_i_ce = (i == k);
        c_i_mem_ready = 1'($urandom);
        c_i_opcode = 6'($urandom);
        @(negedge c_clk);
        total++;
        if (wa !== 18'h0 || wb !== 18'h0) begin bad++; $display("FAIL %s idle ctrl got=%h/%h exp=0", tag, wa, wb); end
        total++;
        if (ra !== 32'(cnt)) begin bad++; $display("FAIL %s idle retired got=%0d exp=%0d", tag, ra, 32'(cnt)); end
        @(posedge c_clk);
        #1;
      end
    end
  endtask

  task automatic test_reset;
    do_reset(2, "reset");
  endtask

  task automatic test_rtype;
    do_instr(OP_R, 0, 0, 1'b0, -1, "rtype");
    total++;
    if (ra !== 32'd1) begin bad++; $display("FAIL rtype count got=%0d exp=1", ra); end
  endtask

  task automatic test_lw_wait;
    do_instr(OP_LW, 0, 3, 1'b0, -1, "lw_wait");
    total++;
    if (ra !== 32'd2) begin bad++; $display("FAIL lw_wait count got=%0d exp=2", ra); end
  endtask

  task automatic test_back_to_back;
    int unsigned c0;
    c0 = cnt;
    do_instr(OP_BEQ, 0, 0, 1'b0, -1, "b2b_beq");
    do_instr(OP_J, 0, 0, 1'b0, -1, "b2b_j");
    total++;
    if (ra !== 32'(c0 + 2)) begin bad++; $display("FAIL b2b count got=%0d exp=%0d", ra, c0 + 2); end
  endtask

  task automatic test_illegal;
    do_instr(6'h3F, 0, 0, 1'b0, -1, "illegal");
    do_instr(OP_ADDI, 1, 0, 1'b0, -1, "after_illegal");
    do_instr(OP_SW, 0, 2, 1'b0, -1, "sw");
  endtask

  task automatic test_ce_drop;
    do_instr(OP_R, 0, 0, 1'b1, -1, "ce_drop");
    do_instr(OP_SW, 0, 1, 1'b1, -1, "ce_drop_sw");
  endtask

  task automatic test_timeout;
    do_instr(OP_R, WM - 1, 0, 1'b0, -1, "late_fetch");
    do_instr(OP_LW, 0, WM - 1, 1'b0, -1, "late_rd");
    do_instr(OP_SW, 0, WM - 1, 1'b0, -1, "late_wr");
    total++;
    if (wa[0] !== 1'b0) begin bad++; $display("FAIL timeout fault got=%b exp=0", wa[0]); end
  endtask

  task automatic test_fault;
    do_instr(OP_R, WM, 0, 1'b0, -1, "fault_fetch");
    total++;
    if (wa !== FLT) begin bad++; $display("FAIL fault sticky got=%h exp=%h", wa, FLT); end
    do_reset(1, "fault_clr");
    do_instr(OP_LW, 0, WM, 1'b0, -1, "fault_rd");
    do_reset(1, "fault_rd_clr");
    do_instr(OP_SW, 0, WM, 1'b0, -1, "fault_wr");
    do_reset(1, "fault_wr_clr");
  endtask

  task automatic test_reset_mid_write;
    do_instr(OP_SW, 0, 5, 1'b0, 5, "mid_wr");
    total++;
    if (wa[13] !== 1'b1) begin bad++; $display("FAIL mid_wr memwrite got=%b exp=1", wa[13]); end
    do_reset(1, "mid_wr_rst");
    do_instr(OP_SW, 0, WM - 1, 1'b0, -1, "after_mid_wr");
  endtask

  task automatic test_wrap;
    do_reset(1, "wrap");
    repeat (15) do_instr(OP_R, 0, 0, 1'b0, -1, "wrap_fill");
    total++;
    if (rb !== 4'd15) begin bad++; $display("FAIL wrap preload got=%0d exp=15", rb); end
    do_instr(OP_R, 0, 0, 1'b0, -1, "wrap");
    total++;
    if (rb !== 4'd0 || ra !== 32'd16) begin bad++; $display("FAIL wrap count got=%0d/%0d exp=0/16", rb, ra); end
  endtask

  task automatic test_random;
    logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] op;
    int fw, mw;
    bit stop;
    for (int t = 0; t < 80; t++) begin
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 6) == 0)
        do op = 6'($urandom); while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      fw = ($urandom_range(0, 12) == 0) ? $urandom_range(WM - 1, WM) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 8) == 0) ? $urandom_range(WM - 1, WM) : $urandom_range(0, 3);
      stop = (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI}) && $urandom_range(0, 5) == 0;
      do_instr(op, fw, mw, stop, -1, "random");
      if (flt) do_reset(1, "random_clr");
    end
  endtask

  initial begin
    c_rst = 1'b0;
    c_i_ce = 1'b0;
    c_i_mem_ready = 1'b0;
    c_i_opcode = 6'h0;
    test_reset;
    test_rtype;
    test_lw_wait;
    test_back_to_back;
    test_illegal;
    test_ce_drop;
    test_timeout;
    test_fault;
    test_reset_mid_write;
    test_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
